// File: rtl/de0nano_gpio_bridge.sv
// de0nano_gpio_bridge
//   Sits directly behind the HostMot2 core on the DE0-Nano. Maps the 68 hm2
//   I/O bits and 4 LED bits onto two 36-pin GPIO headers.
//   - Header h, pin p < 34 carries io bit h*34+p.
//   - Header h, pins 34/35 carry LEDs h*2 and h*2+1.
//   All outputs are registered and all inputs pass through a 2-flop
//   synchronizer. A safe-state machine (SAFE -> ARM -> RUN) tristates every
//   I/O pin while safe_req is high. It returns to RUN only after safe_req has
//   stayed low for HOLDOFF consecutive cycles. While not in RUN, the LED pins
//   blink.
//
//   Optional macro GPIO_INPUT_FILTER_EN adds a per-pin glitch filter after the
//   synchronizer: io_in only changes after FILTER_LEN consecutive differing
//   samples.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   io_out/io_oe  hm2 output data / enables (68)
//   io_in         synchronized (optionally filtered) pin data to hm2 (68)
//   led_in        hm2 LED drive (4)
//   safe_req      level-sensitive watchdog bite / forced-safe request
//   gpio_out/oe   pin data / enables, header h pin p at bit h*36+p (72)
//   gpio_in       raw asynchronous pin levels (72)
//   bridge_state  0=SAFE, 1=ARM, 2=RUN (debug view of the state register)
//
// Handshake: none. Every input is sampled on each rising clk edge and every
// output is valid for the whole cycle that follows the edge.
module de0nano_gpio_bridge #(
   parameter int IO_WIDTH      = 68,
   parameter int NUM_GPIO      = 2,
   parameter int GPIO_WIDTH    = 36,
   parameter int MUX_IO_WIDTH  = IO_WIDTH / NUM_GPIO,
   parameter int LED_COUNT     = 4,
   parameter int MUX_LED_WIDTH = LED_COUNT / NUM_GPIO,
   parameter int HOLDOFF       = 1000,
   parameter int BLINK_DIV     = 25000000,
   parameter int FILTER_LEN    = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [IO_WIDTH-1:0]              io_out,
   input  logic [IO_WIDTH-1:0]              io_oe,
   output logic [IO_WIDTH-1:0]              io_in,
   input  logic [LED_COUNT-1:0]             led_in,
   input  logic                             safe_req,
   output logic [NUM_GPIO*GPIO_WIDTH-1:0]   gpio_out,
   output logic [NUM_GPIO*GPIO_WIDTH-1:0]   gpio_oe,
   input  logic [NUM_GPIO*GPIO_WIDTH-1:0]   gpio_in,
   output logic [1:0]                       bridge_state
);

   localparam int PW = NUM_GPIO * GPIO_WIDTH;
   localparam int HW = $clog2(HOLDOFF) + 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      ST_SAFE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // LED pins are permanently driven, so their enables are 1 even in reset.
   function automatic logic [PW-1:0] led_pin_mask();
      logic [PW-1:0] m;
      m = '0;
      for (int h = 0; h < NUM_GPIO; h++)
         for (int k = 0; k < MUX_LED_WIDTH; k++)
            m[h*GPIO_WIDTH + MUX_IO_WIDTH + k] = 1'b1;
      return m;
   endfunction

   localparam logic [PW-1:0] LED_OE_RST = led_pin_mask();

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_q, blink_d;
   logic [PW-1:0]   gpio_out_q, gpio_out_d;
   logic [PW-1:0]   gpio_oe_q, gpio_oe_d;
   logic [IO_WIDTH-1:0] sync1_q, sync1_d;
   logic [IO_WIDTH-1:0] sync2_q, sync2_d;
   logic [IO_WIDTH-1:0] pin_in;
   logic            unused_led_pins;

   // Next state. safe_req wins from any state and takes effect on the next edge.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (safe_req) begin
         state_d    = ST_SAFE;
         hold_cnt_d = '0;
      end else begin
         case (state_q)
            ST_SAFE: begin
               state_d    = ST_ARM;
               hold_cnt_d = '0;
            end
            ST_ARM: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = ST_RUN;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end
            default: begin
               state_d    = ST_SAFE;
               hold_cnt_d = '0;
            end
         endcase
      end
   end

   // Fault blink. Restarts from 0 on every fresh entry into SAFE and keeps
   // running through SAFE->ARM so the blink is continuous while not in RUN.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (state_d == ST_RUN || (state_d == ST_SAFE && state_q != ST_SAFE)) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // Output mapping keys off state_d, so the output register and the state
   // register change on the same edge: no extra cycle when entering/leaving RUN.
   always_comb begin
      gpio_out_d = '0;
      gpio_oe_d  = '0;
      for (int h = 0; h < NUM_GPIO; h++) begin
         for (int p = 0; p < MUX_IO_WIDTH; p++) begin
            if (state_d == ST_RUN) begin
               gpio_out_d[h*GPIO_WIDTH + p] = io_out[h*MUX_IO_WIDTH + p];
               gpio_oe_d[h*GPIO_WIDTH + p]  = io_oe[h*MUX_IO_WIDTH + p];
            end
         end
         for (int k = 0; k < MUX_LED_WIDTH; k++) begin
            gpio_oe_d[h*GPIO_WIDTH + MUX_IO_WIDTH + k] = 1'b1;
            gpio_out_d[h*GPIO_WIDTH + MUX_IO_WIDTH + k] =
               (state_d == ST_RUN) ? led_in[h*MUX_LED_WIDTH + k] : blink_d;
         end
      end
   end

   // Gather the I/O pins into hm2 bit order; LED pin levels are not used.
   always_comb begin
      pin_in          = '0;
      unused_led_pins = 1'b0;
      for (int h = 0; h < NUM_GPIO; h++) begin
         for (int p = 0; p < MUX_IO_WIDTH; p++)
            pin_in[h*MUX_IO_WIDTH + p] = gpio_in[h*GPIO_WIDTH + p];
         for (int k = 0; k < MUX_LED_WIDTH; k++)
            unused_led_pins = unused_led_pins ^ gpio_in[h*GPIO_WIDTH + MUX_IO_WIDTH + k];
      end
   end

   assign sync1_d = pin_in;
   assign sync2_d = sync1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SAFE;
         hold_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         gpio_out_q  <= '0;
         gpio_oe_q   <= LED_OE_RST;
         sync1_q     <= '0;
         sync2_q     <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         gpio_out_q  <= gpio_out_d;
         gpio_oe_q   <= gpio_oe_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
      end
   end

`ifdef GPIO_INPUT_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

   logic [FW-1:0]       filt_cnt_q [IO_WIDTH];
   logic [FW-1:0]       filt_cnt_d [IO_WIDTH];
   logic [IO_WIDTH-1:0] filt_q, filt_d;

   // Count consecutive samples that disagree with the current output; any
   // agreeing sample restarts the count.
   always_comb begin
      filt_d = filt_q;
      for (int n = 0; n < IO_WIDTH; n++) begin
         filt_cnt_d[n] = '0;
         if (sync2_q[n] != filt_q[n]) begin
            if (filt_cnt_q[n] == FILT_LAST)
               filt_d[n] = sync2_q[n];
            else
               filt_cnt_d[n] = filt_cnt_q[n] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= '0;
         for (int n = 0; n < IO_WIDTH; n++)
            filt_cnt_q[n] <= '0;
      end else begin
         filt_q <= filt_d;
         for (int n = 0; n < IO_WIDTH; n++)
            filt_cnt_q[n] <= filt_cnt_d[n];
      end
   end

   assign io_in = filt_q;
`else
   assign io_in = sync2_q;
`endif

   assign gpio_out     = gpio_out_q;
   assign gpio_oe      = gpio_oe_q;
   assign bridge_state = state_q;

endmodule

// File: tb/tb_de0nano_gpio_bridge.sv
// tb_de0nano_gpio_bridge
//   Randomized plus directed stimulus for de0nano_gpio_bridge with
//   HOLDOFF=8, BLINK_DIV=4 and FILTER_LEN=4. The driver computes the expected
//   post-edge outputs from a behavioural model and queues them. A monitor pops
//   one entry per cycle, #1 after the rising edge, and compares.
module tb_de0nano_gpio_bridge;

   localparam int HOLDOFF    = 8;
   localparam int BLINK_DIV  = 4;
   localparam int FILTER_LEN = 4;
   localparam int EW         = 72 + 72 + 68 + 2;

   logic        clk;
   logic        reset;
   logic [67:0] io_out;
   logic [67:0] io_oe;
   logic [67:0] io_in;
   logic [3:0]  led_in;
   logic        safe_req;
   logic [71:0] gpio_out;
   logic [71:0] gpio_oe;
   logic [71:0] gpio_in;
   logic [1:0]  bridge_state;

   de0nano_gpio_bridge #(
      .HOLDOFF   (HOLDOFF),
      .BLINK_DIV (BLINK_DIV),
      .FILTER_LEN(FILTER_LEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .io_out      (io_out),
      .io_oe       (io_oe),
      .io_in       (io_in),
      .led_in      (led_in),
      .safe_req    (safe_req),
      .gpio_out    (gpio_out),
      .gpio_oe     (gpio_oe),
      .gpio_in     (gpio_in),
      .bridge_state(bridge_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset    = 1'b1;
      safe_req = 1'b0;
      io_out   = '0;
      io_oe    = '0;
      led_in   = '0;
      gpio_in  = '0;
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bridge_state", {70'd0, bridge_state}, {70'd0, e[1:0]});
            chk("gpio_out", gpio_out, e[EW-1 -: 72]);
            chk("gpio_oe", gpio_oe, e[EW-73 -: 72]);
            chk("io_in", {4'd0, io_in}, {4'd0, e[69:2]});
         end
      end
   end

   // ---------------- reference model ----------------
   // m_clear: consecutive clear safe_req samples since the last request/reset.
   // m_age:   non-RUN cycles since the last fresh entry into SAFE.
   int          m_state = 0;
   int          m_clear = 0;
   int          m_age   = 0;
   logic [67:0] m_s1    = '0;
   logic [67:0] m_s2    = '0;
   logic [67:0] m_filt  = '0;
   logic [67:0] fhist[$];

   function automatic int io_pin(input int n);
      return (n / 34) * 36 + (n % 34);
   endfunction

   function automatic int led_pin(input int l);
      return (l / 2) * 36 + 34 + (l % 2);
   endfunction

   function automatic logic [67:0] pins_to_io(input logic [71:0] g);
      logic [67:0] r;
      for (int n = 0; n < 68; n++) r[n] = g[io_pin(n)];
      return r;
   endfunction

   function automatic logic [71:0] rnd72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[71:0];
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic s, input logic [67:0] o,
                        input logic [67:0] oe, input logic [3:0] l, input logic [71:0] g);
      int          ns;
      logic [71:0] e_out, e_oe;
      logic [67:0] e_in, f0;
      logic        blink, same;
      @(negedge clk);
      reset = r; safe_req = s; io_out = o; io_oe = oe; led_in = l; gpio_in = g;

      if (r) begin
         ns = 0; m_clear = 0; m_age = 0;
         m_s1 = '0; m_s2 = '0; m_filt = '0;
         for (int i = 0; i < FILTER_LEN; i++) fhist[i] = '0;
      end else begin
         // The filter sees the synchronizer output present before this edge.
         fhist.push_back(m_s2);
         void'(fhist.pop_front());
         f0 = fhist[0];
         for (int b = 0; b < 68; b++) begin
            same = 1'b1;
            for (int i = 1; i < FILTER_LEN; i++) begin
               logic [67:0] fi;
               fi = fhist[i];
               if (fi[b] != f0[b]) same = 1'b0;
            end
            if (same && f0[b] != m_filt[b]) m_filt[b] = f0[b];
         end
         m_s2 = m_s1;
         m_s1 = pins_to_io(g);
         if (s) begin
            m_age   = (m_state == 0) ? m_age + 1 : 0;
            m_clear = 0;
            ns      = 0;
         end else begin
            if (m_clear <= HOLDOFF) m_clear++;
            ns = (m_clear <= HOLDOFF) ? 1 : 2;
            if (ns != 2) m_age++;
         end
      end

      blink = ((m_age / BLINK_DIV) % 2) == 1;
      e_out = '0;
      e_oe  = '0;
      for (int n = 0; n < 68; n++) begin
         if (ns == 2) begin
            e_out[io_pin(n)] = o[n];
            e_oe[io_pin(n)]  = oe[n];
         end
      end
      for (int k = 0; k < 4; k++) begin
         e_oe[led_pin(k)]  = 1'b1;
         e_out[led_pin(k)] = (ns == 2) ? l[k] : blink;
      end
`ifdef GPIO_INPUT_FILTER_EN
      e_in = m_filt;
`else
      e_in = m_s2;
`endif
      m_state = ns;
      exp_q.push_back({e_out, e_oe, e_in, 2'(ns)});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [67:0] o, oe;
      logic [71:0] g;
      for (int i = 0; i < FILTER_LEN; i++) fhist.push_back('0);

      // Reset, including reset together with safe_req.
      repeat (3) drive(1'b1, 1'($urandom_range(0, 1)), 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);
      // SAFE -> 8 ARM cycles -> RUN with random hm2 outputs.
      repeat (14) drive(1'b0, 1'b0, 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);

      // Directed io bits 0 and 34 -> pins 0 and 36.
      o = '0; o[0] = 1'b1; o[34] = 1'b1;
      oe = '0; oe[0] = 1'b1; oe[34] = 1'b1;
      repeat (3) drive(1'b0, 1'b0, o, oe, 4'h0, '0);

      // One-cycle safe pulse from RUN, then full holdoff.
      drive(1'b0, 1'b1, o, oe, 4'h5, '0);
      repeat (12) drive(1'b0, 1'b0, o, oe, 4'ha, '0);

      // Interrupt ARM at count 5, then require a full holdoff again.
      drive(1'b0, 1'b1, o, oe, 4'h3, '0);
      repeat (6) drive(1'b0, 1'b0, o, oe, 4'h3, '0);
      drive(1'b0, 1'b1, o, oe, 4'h3, '0);
      repeat (12) drive(1'b0, 1'b0, 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);

      // Sit in SAFE: LEDs blink and ignore led_in.
      repeat (20) drive(1'b0, 1'b1, 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);
      repeat (12) drive(1'b0, 1'b0, 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);

      // Pulses of length 1..6 on pin 40 (io bit 38), plus the LED pins.
      for (int len = 1; len <= 6; len++) begin
         g = '0; g[40] = 1'b1; g[34] = 1'b1; g[71] = 1'b1;
         repeat (len) drive(1'b0, 1'b0, '0, '0, 4'h0, g);
         repeat (10) drive(1'b0, 1'b0, '0, '0, 4'h0, '0);
      end

      // Reset with safe_req asserted mid-RUN.
      drive(1'b1, 1'b1, 68'(rnd72()), 68'(rnd72()), 4'hf, rnd72());
      repeat (12) drive(1'b0, 1'b0, 68'(rnd72()), 68'(rnd72()), 4'($urandom), '0);

      // Random phase: rare safe requests and resets, slowly changing pins.
      g = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 4) == 0) g[$urandom_range(0, 71)] ^= 1'b1;
         if ($urandom_range(0, 29) == 0) g = rnd72();
         drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 24) == 0),
               68'(rnd72()), 68'(rnd72()), 4'($urandom), g);
      end

      @(posedge clk);
      #2;
      chk("queue_drained", 72'(exp_q.size()), 72'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/de0nano_gpio_bridge.md
Name: de0nano_gpio_bridge

Overview:
- Stage directly downstream of the HostMot2 core on the DE0-Nano build.
- Maps the 68 hm2 I/O bits (4 ports x 17) and 4 LEDs onto the two 36-pin GPIO headers: 34 I/O plus 2 LEDs per header.
- Registers all outputs and synchronizes all inputs.
- A safe-state machine forces every I/O pin to high-Z on a watchdog bite, and holds that state until the request has stayed clear for a programmable holdoff.

Parameters:
- IO_WIDTH, 68, total hm2 I/O bits.
- NUM_GPIO, 2, number of GPIO headers.
- GPIO_WIDTH, 36, pins per header.
- MUX_IO_WIDTH, 34, hm2 bits per header (IO_WIDTH/NUM_GPIO).
- LED_COUNT, 4, hm2 LED bits.
- MUX_LED_WIDTH, 2, LEDs per header (LED_COUNT/NUM_GPIO).
- HOLDOFF, 1000, consecutive clear cycles required before leaving safe state (>=1).
- BLINK_DIV, 25000000, half-period in clocks of the fault blink on the LED pins.
- FILTER_LEN, 4, stable samples required by the optional input filter (>=2).

Ports:
- clk  in  1  system clock (single domain)
- reset  in  1  synchronous, active-high reset
- io_out  in  68  hm2 output data
- io_oe  in  68  hm2 output enables
- io_in  out  68  synchronized pin data to hm2
- led_in  in  4  hm2 LED drive
- safe_req  in  1  watchdog bite / host-forced safe request, level sensitive
- gpio_out  out  72  pin data, header h pin p at bit h*36+p
- gpio_oe  out  72  pin output enables
- gpio_in  in  72  raw pin levels (asynchronous)
- bridge_state  out  2  0=SAFE, 1=ARM, 2=RUN

Behaviour:
Pin mapping, header h in {0,1}:
- Pin p<34 carries io bit h*34+p.
- Pin 34+k (k in {0,1}) carries LED h*2+k.
- LED pins are always output (oe=1). Their gpio_in bits are ignored.

Output path:
- gpio_out/gpio_oe are registered: 1-cycle latency from io_out/io_oe/led_in in RUN.
- In SAFE or ARM, all I/O pins have oe=0 and out=0.
- In SAFE or ARM, LED pins drive the blink signal:
  - Blink counter counts 0..BLINK_DIV-1 and toggles on wrap.
  - Blink output starts at 0 on entry to SAFE.
  - Counter is held at 0 in RUN.

Input path:
- 2-flop synchronizer per pin; io_in bit n = synced gpio_in of its mapped pin.
- Latency: 2 cycles.
- io_in does not depend on state.

State machine:
- SAFE:
  - Entered on reset, or from any state when safe_req=1 (takes effect on the next edge).
  - Holdoff counter is held at 0.
  - safe_req=0 -> ARM.
- ARM:
  - Counter increments every cycle with safe_req=0.
  - safe_req=1 -> SAFE, counter cleared.
  - When counter==HOLDOFF-1 and safe_req=0 -> RUN.
  - HOLDOFF=1 means ARM lasts exactly one cycle.
- RUN: passthrough; safe_req=1 -> SAFE.

Timing and boundary rules:
- The first cycle after safe_req is sampled high already shows gpio_oe I/O bits = 0, i.e. the same register stage as normal outputs. No extra cycle.
- The first RUN cycle shows the registered io_out/io_oe.
- Reset values: gpio_out=0, gpio_oe=0 except LED pins (oe=1, out=0), io_in=0, synchronizer flops=0, bridge_state=SAFE.
- Reset asserted mid-RUN: next edge is SAFE, with outputs as above.
- reset and safe_req together: reset wins; result is identical.
- Holdoff counter width: clog2(HOLDOFF)+1. The counter never wraps; it saturates only via the state exit.

Optional Feature:
Macro: GPIO_INPUT_FILTER_EN
- Defined:
  - After the synchronizer, each I/O pin has a glitch filter (per-pin counter).
  - io_in updates only after FILTER_LEN consecutive identical synced samples that differ from the current io_in.
  - Latency is 2+FILTER_LEN cycles.
  - Filter counters and outputs reset to 0.
- Undefined: no filter logic is generated; io_in is the 2-flop output, latency 2.

Test Plan:
- Reset, then hold safe_req=0 with HOLDOFF=8 -> bridge_state SAFE, ARM for 8 cycles, then RUN. No I/O oe asserts before RUN. LED oe=1 throughout.
- In RUN drive io_out=68'h0_0000_0000_0000_0001 with io_oe[0]=1 and io_oe[34]=1, io_out[34]=1 -> next cycle gpio_out[0]=1, gpio_oe[0]=1, gpio_out[36]=1, gpio_oe[36]=1. All others 0.
- In RUN pulse safe_req=1 for one cycle -> next cycle all 68 I/O oe=0 and state=SAFE. Then ARM for HOLDOFF cycles before RUN again.
- In ARM at count 5 of 8, assert safe_req -> SAFE, counter cleared. Release -> a full 8 ARM cycles are required.
- Toggle gpio_in[40] (header 1, pin 4 -> io bit 38) -> io_in[38] follows after 2 cycles. With GPIO_INPUT_FILTER_EN and FILTER_LEN=4, a 3-cycle pulse is rejected and a 4-cycle pulse appears 6 cycles after the edge.
- Set BLINK_DIV=4 and stay in SAFE -> LED pins 34,35,70,71 toggle every 4 cycles starting at 0. Led_in changes are ignored until RUN.
